uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8-data/odd-parity receiver.
- Samples a raw asynchronous serial line using an internal oversampling tick generator.
- Supports configurable data width, runtime parity mode (none/odd/even) and 1 or 2 stop bits.
- Delivers each frame with error status over a valid/ready handshake to the downstream consumer (FIFO or register block).

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line.
- OVERSAMPLE, 16, sample ticks per bit, legal 8 or 16.
- DIV_WIDTH, 16, width of the baud divisor input.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- divisor  input  DIV_WIDTH  sample tick every divisor+1 clk cycles.
- parity_mode  input  2  00 none, 01 odd, 10 even, 11 none.
- two_stop  input  1  1 = two stop bits checked.
- rx  input  1  raw serial line, idle high.
- rx_data  output  DATA_BITS  received data.
- rx_valid  output  1  rx_data/status valid.
- rx_ready  input  1  consumer accepts when rx_valid&&rx_ready.
- parity_err  output  1  parity mismatch on the held frame.
- frame_err  output  1  a stop bit was sampled low on the held frame.
- break_det  output  1  data, parity and stop bits were all zero.
- overrun  output  1  one-cycle pulse when a completed frame was dropped.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs are 0. FSM is IDLE, counters are 0, synchroniser flops are 1.
- Reset has priority over every other event, including mid-frame; the partial frame is discarded.
- rx passes through a 2-flop synchroniser (rxs). Latency from rx to rxs is 2 clk.
- Tick generator:
  - Counter runs from 0 to divisor, asserting tick for one clk at wrap.
  - divisor=0 gives a tick every clk.
  - divisor is latched at the start-bit falling edge. Changes mid-frame do not affect that frame.
  - The counter restarts at 0 on start detection.
- IDLE: a falling edge on rxs moves the FSM to START and clears the sample counter.
- START: at tick OVERSAMPLE/2, take a majority-of-3 sample.
  - Sample = 1: false start. Return to IDLE with no output.
  - Sample = 0: go to DATA and reset the sample counter.
- Bit sampling: majority of rxs over ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit. The bit ends at tick OVERSAMPLE-1.
- DATA: shift in DATA_BITS bits, LSB first. Then go to PARITY if parity_mode is 01/10, else to STOP1.
- PARITY: odd mode requires XOR(data, parity)=1; even mode requires it to be 0.
- STOP1: a low sample sets frame_err for this frame. If two_stop=1, go to STOP2; otherwise complete the frame.
  - Completion happens at the mid-bit sample, not at the end of the bit, so back-to-back frames are not missed.
- STOP2: same check as STOP1, then complete the frame.
- break_det is set when every sampled bit after start is 0. It implies frame_err=1.
- Frame completion, with rx_valid=0:
  - Load rx_data and the three status flags.
  - Assert rx_valid on the next clk. FSM returns to IDLE.
- Frame completion with rx_valid=1 and no handshake that cycle:
  - Frame is dropped and the held data/flags are unchanged.
  - overrun pulses high for 1 clk.
- Completion in the same cycle as a handshake: the handshake takes effect first, so the new frame loads and rx_valid stays 1. No overrun.
- rx_valid stays high until the handshake. rx_data and flags are stable while rx_valid=1.
- Flags clear on the handshake unless a new frame loads in the same cycle.
- busy=1 in START, DATA, PARITY, STOP1 and STOP2.
- After break, IDLE waits for rxs=1 (line recovered) before accepting a new falling edge.

Test Plan:
- Correct odd-parity frame. Setup: clk 10 ns, divisor=13 (14-clk tick, 224 clk/bit), parity_mode=01, two_stop=0. Send 0xAA with parity 1 and stop 1. Required: rx_valid=1, rx_data=0xAA, parity_err=0, frame_err=0. rx_valid holds until rx_ready pulses, then drops next clk.
- Parity error. Same setup; send 0x55 with parity 0. Required: rx_data=0x55, parity_err=1. Then switch to parity_mode=10 and send 0x55 with parity 0. Required: parity_err=0.
- Framing error and break.
  - Send 0xF0 with parity 1 and stop bit held 0. Required: frame_err=1, break_det=0.
  - Hold rx low for 12 bit times. Required: rx_data=0x00, frame_err=1, break_det=1, and no new frame until rx returns high.
- False start and noise rejection.
  - A 3-tick low glitch on idle rx gives no rx_valid and busy returns to 0.
  - A 1-tick glitch mid data bit of 0xCC leaves rx_data=0xCC.
- Overrun and back-to-back.
  - With rx_ready=0, send 0x0F then 0xCC back-to-back with no idle gap. Required: first frame held (rx_data=0x0F) and overrun pulses for one clk.
  - Repeat with rx_ready=1. Required: both frames delivered and no overrun.
- Reset and configuration changes.
  - Assert reset mid-DATA of 0xAA. Required: all outputs 0 next clk and no frame is delivered.
  - Send two_stop=1 with second stop 0. Required: frame_err=1.
  - Changing divisor mid-frame does not corrupt the current frame.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with an internal oversampling tick
// generator, runtime parity (none/odd/even), 1 or 2 stop bits, and a
// valid/ready output holding one frame plus its error status.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   divisor         sample tick every divisor+1 clk (latched at start edge)
//   parity_mode     00/11 none, 01 odd, 10 even
//   two_stop        1 = check two stop bits
//   rx              raw serial line, idle high
//   rx_data         received data (LSB first on the line)
//   rx_valid        rx_data and status flags valid until rx_ready handshake
//   rx_ready        consumer accept
//   parity_err      parity mismatch on the held frame
//   frame_err       a stop bit sampled low on the held frame
//   break_det       every bit after start sampled low
//   overrun         one-clk pulse when a completed frame is dropped
//   busy            receiver is inside a frame
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] S_LO     = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] S_MID    = CW'(OVERSAMPLE/2);
    localparam logic [CW-1:0] S_HI     = CW'(OVERSAMPLE/2 + 1);
    localparam logic [CW-1:0] S_END    = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
    state_t state, state_d;

    logic                 sync1, rxs, rxs_d;
    logic [DIV_WIDTH-1:0] div_q, tick_cnt;
    logic [CW-1:0]        samp_cnt;
    logic                 s_lo, s_mid;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, ferr_acc, zero_acc, two_q, brk_wait;
    logic [1:0]           pmode_q;

    logic tick, mid, endb, maj, fall, complete, par_x;
    logic fe_fin, zero_fin, pe_fin;

    // Ticks only run inside a frame; in IDLE the counter is held at 0 so it
    // restarts cleanly from the start edge.
    assign tick  = (state != IDLE) && (tick_cnt == div_q);
    // Each bit owns OVERSAMPLE ticks; the vote resolves on the third sample
    // and the bit boundary is the last tick.
    assign mid   = tick && (samp_cnt == S_HI);
    assign endb  = tick && (samp_cnt == S_END);
    assign maj   = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);
    // After a break the line must go high again before a new edge counts.
    assign fall  = rxs_d & ~rxs & ~brk_wait;
    assign busy  = (state != IDLE);

    // Final status includes the stop bit resolving in this very cycle.
    assign fe_fin   = ferr_acc | ~maj;
    assign zero_fin = zero_acc & ~maj;
    assign par_x    = (^shreg) ^ par_bit;
    assign pe_fin   = (pmode_q == 2'b01) ? ~par_x :
                      (pmode_q == 2'b10) ?  par_x : 1'b0;

    always_comb begin
        state_d  = state;
        complete = 1'b0;
        case (state)
            IDLE:   if (fall) state_d = START;
            START:  if (mid && maj) state_d = IDLE;          // false start
                    else if (endb)  state_d = DATA;
            DATA:   if (endb && bit_cnt == LAST_BIT)
                        state_d = (pmode_q == 2'b01 || pmode_q == 2'b10) ? PARITY : STOP1;
            PARITY: if (endb) state_d = STOP1;
            // Completing at mid stop bit leaves half a bit to catch the next
            // start edge of a back-to-back frame.
            STOP1:  if (mid && !two_q) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else if (endb) state_d = STOP2;
            STOP2:  if (mid) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sync1      <= 1'b1;
            rxs        <= 1'b1;
            rxs_d      <= 1'b1;
            div_q      <= '0;
            tick_cnt   <= '0;
            samp_cnt   <= '0;
            s_lo       <= 1'b0;
            s_mid      <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ferr_acc   <= 1'b0;
            zero_acc   <= 1'b0;
            pmode_q    <= '0;
            two_q      <= 1'b0;
            brk_wait   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state   <= state_d;
            sync1   <= rx;
            rxs     <= sync1;
            rxs_d   <= rxs;
            overrun <= 1'b0;

            if (state == IDLE) begin
                tick_cnt <= '0;
                samp_cnt <= '0;
                if (brk_wait && rxs) brk_wait <= 1'b0;
                if (fall) begin
                    // Frame configuration is frozen for the whole frame.
                    div_q    <= divisor;
                    pmode_q  <= parity_mode;
                    two_q    <= two_stop;
                    bit_cnt  <= '0;
                    par_bit  <= 1'b0;
                    ferr_acc <= 1'b0;
                    zero_acc <= 1'b1;
                end
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + DIV_WIDTH'(1);
                if (tick) begin
                    samp_cnt <= (samp_cnt == S_END) ? '0 : samp_cnt + CW'(1);
                    if (samp_cnt == S_LO)  s_lo  <= rxs;
                    if (samp_cnt == S_MID) s_mid <= rxs;
                end
                if (mid) begin
                    case (state)
                        DATA: begin
                            shreg    <= {maj, shreg[DATA_BITS-1:1]};
                            zero_acc <= zero_acc & ~maj;
                        end
                        PARITY: begin
                            par_bit  <= maj;
                            zero_acc <= zero_acc & ~maj;
                        end
                        STOP1, STOP2: begin
                            ferr_acc <= ferr_acc | ~maj;
                            zero_acc <= zero_acc & ~maj;
                        end
                        default: ;
                    endcase
                end
                if (endb && state == DATA) bit_cnt <= bit_cnt + BW'(1);
            end

            // A handshake in the completion cycle frees the holding register
            // first, so the new frame loads instead of overrunning.
            if (complete) begin
                brk_wait <= zero_fin;
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= pe_fin;
                    frame_err  <= fe_fin;
                    break_det  <= zero_fin;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                break_det  <= 1'b0;
            end
        end
    end
endmodule
